stage_except_collect: RTL
=========================

// Module: stage_except_collect
// PURPOSE
//  Parametrised per-stage exception collector and pipeline register for the in-order core.
//  Each stage has NUM_SRC exception sources. The lowest index source wins when several are set.
//  A new exception is merged with the pack arriving from upstream; an upstream exception always wins.
//  The merged pack is registered toward the next stage. A HELD state masks further new raises
//  until the pipeline is flushed, so one trap is raised per flush window.
// PARAMETERS
//  XLEN     64  width of epc / ecause / etval
//  NUM_SRC  4   number of local exception sources; index 0 = highest priority
//  CNT_W    16  width of each per-source counter (EXCEPT_CNT_EN only)
// PORTS
//  clk              in   1              clock; all state on rising edge
//  rst              in   1              synchronous active-high reset
//  stall            in   1              hold output register and state
//  flush            in   1              clear output register; release HELD
//  valid_i          in   1              instruction in this stage is valid
//  pc_i             in   XLEN           PC of the stage instruction; becomes epc of a new exception
//  src_valid_i      in   NUM_SRC        per-source exception request
//  src_cause_i      in   NUM_SRC*XLEN   per-source ecause; slice i = [i*XLEN +: XLEN]
//  src_tval_i       in   NUM_SRC*XLEN   per-source etval, same slicing
//  up_except_i      in   1              upstream pack valid
//  up_epc_i/up_ecause_i/up_etval_i in XLEN  upstream pack fields
//  dn_except_o      out  1              registered pack valid, to next stage
//  dn_epc_o/dn_ecause_o/dn_etval_o out XLEN registered pack fields
//  except_happen_o  out  1              combinational: this stage raises a new exception this cycle
//  held_o           out  1              state == HELD
//  cnt_o            out  NUM_SRC*CNT_W  per-source counters
// BEHAVIOUR
//  - new_hit = valid_i & |src_valid_i & ~up_except_i & (state==IDLE).
//  - sel = lowest i with src_valid_i[i] set.
//    New pack = {1, pc_i, src_cause_i[sel], src_tval_i[sel]}.
//  - merged = up_except_i ? upstream pack : (new_hit ? new pack : all zero).
//  - except_happen_o = new_hit & ~flush. It is combinational and has zero latency.
//  - Output register, priority rst > flush > stall > load:
//    - rst or flush: all dn_* outputs = 0.
//    - stall: all dn_* outputs hold.
//    - otherwise: dn_* <= merged. Latency is 1 cycle.
//  - FSM has two states, IDLE and HELD. Reset state is IDLE.
//    - IDLE -> HELD when new_hit & ~stall & ~flush.
//    - HELD -> IDLE when flush. Flush wins over a same-cycle raise; the state stays IDLE.
//    - In HELD, local sources are masked. Upstream packs still pass through unchanged.
//    - A new_hit while stalled keeps except_happen_o high each stalled cycle; the state stays IDLE.
//  - With valid_i=0, local sources are ignored. An upstream pack still propagates.
//  - Reset values: dn_except_o=0, dn_epc_o=0, dn_ecause_o=0, dn_etval_o=0, held_o=0, cnt_o=0.
//    except_happen_o follows its equation.
//  - rst asserted mid-operation clears the register, state and counters in the same edge.
// CONFIGURATION
//  EXCEPT_CNT_EN defined:
//    - cnt_o slice sel increments by 1 on every committed raise (IDLE->HELD transition).
//    - Each counter saturates at 2^CNT_W-1.
//    - Counters are cleared only by rst; flush does not affect them.
//  EXCEPT_CNT_EN undefined: cnt_o is tied to 0 and no counter flops exist.
// TESTING
//  1. src_valid_i=4'b0110, valid_i=1, pc_i=0x8000_0010, no upstream pack
//     -> except_happen_o=1 that cycle.
//     -> Next cycle: dn_except_o=1, dn_epc_o=0x8000_0010, dn_ecause_o=src_cause[1], held_o=1.
//  2. up_except_i=1 (ecause=2) with src_valid_i=4'b0001 in the same cycle
//     -> except_happen_o=0. Next cycle: dn_ecause_o=2, held_o=0.
//  3. In HELD, src_valid_i=4'b1000 -> except_happen_o=0 and dn_except_o=0.
//     Then flush=1 -> held_o=0 next cycle.
//     A raise on the following cycle is accepted again.
//  4. stall=1 for 3 cycles with src_valid_i=1 -> dn_* outputs hold and state stays IDLE.
//     Stall drops -> the pack loads and the state goes to HELD.
//  5. flush=1 and new_hit in the same cycle -> except_happen_o=0, dn_except_o=0, held_o stays 0.
//  6. EXCEPT_CNT_EN with CNT_W=2: 4 raises of source 2, each followed by a flush
//     -> cnt_o slice 2 = 3 (saturated). rst -> 0.

Source files
------------

// File: rtl/stage_except_collect.sv
// stage_except_collect: per-stage exception priority merge, pipeline register and one-trap-per-flush FSM.
// Optional per-source raise counters are built only when EXCEPT_CNT_EN is defined.
module stage_except_collect #(
  parameter int XLEN    = 64,
  parameter int NUM_SRC = 4,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     valid_i,
  input  logic [XLEN-1:0]          pc_i,
  input  logic [NUM_SRC-1:0]       src_valid_i,
  input  logic [NUM_SRC*XLEN-1:0]  src_cause_i,
  input  logic [NUM_SRC*XLEN-1:0]  src_tval_i,
  input  logic                     up_except_i,
  input  logic [XLEN-1:0]          up_epc_i,
  input  logic [XLEN-1:0]          up_ecause_i,
  input  logic [XLEN-1:0]          up_etval_i,
  output logic                     dn_except_o,
  output logic [XLEN-1:0]          dn_epc_o,
  output logic [XLEN-1:0]          dn_ecause_o,
  output logic [XLEN-1:0]          dn_etval_o,
  output logic                     except_happen_o,
  output logic                     held_o,
  output logic [NUM_SRC*CNT_W-1:0] cnt_o
);
  localparam int SEL_W = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
  typedef enum logic {IDLE, HELD} state_t;
  state_t state_q, state_d;
  logic [SEL_W-1:0] sel;
  logic new_hit, raise;
  logic m_except;
  logic [XLEN-1:0] m_epc, m_ecause, m_etval;
  logic dn_except_q;
  logic [XLEN-1:0] dn_epc_q, dn_ecause_q, dn_etval_q;
  always_comb begin
    sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) if (src_valid_i[i]) sel = SEL_W'(i);
  end
  assign new_hit  = valid_i & |src_valid_i & ~up_except_i & (state_q == IDLE);
  assign raise    = new_hit & ~stall & ~flush;
  assign m_except = up_except_i | new_hit;
  assign m_epc    = up_except_i ? up_epc_i : new_hit ? pc_i : '0;
  assign m_ecause = up_except_i ? up_ecause_i : new_hit ? src_cause_i[sel*XLEN +: XLEN] : '0;
  assign m_etval  = up_except_i ? up_etval_i : new_hit ? src_tval_i[sel*XLEN +: XLEN] : '0;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      dn_except_q <= 1'b0;
      dn_epc_q    <= '0;
      dn_ecause_q <= '0;
      dn_etval_q  <= '0;
    end else if (!stall) begin
      dn_except_q <= m_except;
      dn_epc_q    <= m_epc;
      dn_ecause_q <= m_ecause;
      dn_etval_q  <= m_etval;
    end
  end
  // raise already excludes stall, so a stalled hit leaves the state untouched
  assign state_d = flush ? IDLE : raise ? HELD : state_q;
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  assign dn_except_o     = dn_except_q;
  assign dn_epc_o        = dn_epc_q;
  assign dn_ecause_o     = dn_ecause_q;
  assign dn_etval_o      = dn_etval_q;
  assign except_happen_o = new_hit & ~flush;
  assign held_o          = state_q == HELD;
`ifdef EXCEPT_CNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_SRC];
  always_ff @(posedge clk) begin
    for (int j = 0; j < NUM_SRC; j++) begin
      if (rst) cnt_q[j] <= '0;
      else if (raise && sel == SEL_W'(j) && cnt_q[j] != '1) cnt_q[j] <= cnt_q[j] + 1'b1;
    end
  end
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_cnt
    assign cnt_o[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`else
  assign cnt_o = '0;
`endif
endmodule
